// File: rtl/branch_predecoder_if.sv
// Fetch <-> branch predecoder bundle: the instruction stream in, the redirect request out.
// master = fetch side, slave = predecoder.
interface branch_predecoder_if;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush_all;
    logic        flush;
    logic        target_valid;
    logic [31:0] target_pc;

    modport master (
        output inst_valid,
        output inst,
        output inst_pc,
        output flush_all,
        input  flush,
        input  target_valid,
        input  target_pc
    );

    modport slave (
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  flush_all,
        output flush,
        output target_valid,
        output target_pc
    );
endinterface

// File: rtl/branch_predecoder.sv
// Static LoongArch32 branch predecoder: redirects fetch on B/BL and backward conditional branches.
// Optional return-address stack enabled by defining BRANCH_PREDECODER_RAS_EN.
module branch_predecoder #(
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    branch_predecoder_if.slave bus
);

    localparam logic [5:0] OP_BEQZ = 6'b010000;
    localparam logic [5:0] OP_BNEZ = 6'b010001;
    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGE  = 6'b011001;
    localparam logic [5:0] OP_BLTU = 6'b011010;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] target_pc_r;

    logic [5:0]  opcode_s;
    logic [31:0] off26_s;
    logic [31:0] off21_s;
    logic [31:0] off16_s;
    logic        accept_s;
    logic        taken_s;
    logic        redirect_s;
    logic [31:0] pred_pc_s;

    assign opcode_s = bus.inst[31:26];
    assign off26_s  = {{4{bus.inst[9]}}, bus.inst[9:0], bus.inst[25:10], 2'b00};
    assign off21_s  = {{9{bus.inst[4]}}, bus.inst[4:0], bus.inst[25:10], 2'b00};
    assign off16_s  = {{14{bus.inst[25]}}, bus.inst[25:10], 2'b00};

    // An instruction is only looked at in IDLE and outside a pipeline-wide flush.
    assign accept_s = (state_r == IDLE) && bus.inst_valid && !bus.flush_all;

`ifdef BRANCH_PREDECODER_RAS_EN
    localparam int              PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]  CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [31:0]      ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_r;
    logic [PTR_W:0]   ras_cnt_r;
    logic [31:0]      ras_top_s;
    logic             is_ret_s;
    logic             is_link_s;
    logic             push_s;
    logic             pop_s;

    // ras_ptr_r points at the next free slot, so the newest entry sits just below it.
    assign ras_top_s = ras_mem_r[ras_ptr_r - PTR_ONE];
    assign is_ret_s  = (opcode_s == OP_JIRL) && (bus.inst[4:0] == 5'd0) &&
                       (bus.inst[9:5] == 5'd1) && (bus.inst[25:10] == 16'd0);
    assign is_link_s = (opcode_s == OP_BL) ||
                       ((opcode_s == OP_JIRL) && (bus.inst[4:0] == 5'd1));
    assign push_s    = accept_s && is_link_s;
    assign pop_s     = accept_s && is_ret_s && (ras_cnt_r != CNT_ZERO);
`endif

    // Static prediction and target computation for the presented instruction.
    always_comb begin
        taken_s   = 1'b0;
        pred_pc_s = 32'h0000_0000;
        case (opcode_s)
            OP_B, OP_BL: begin
                taken_s   = 1'b1;
                pred_pc_s = bus.inst_pc + off26_s;
            end
            OP_BEQZ, OP_BNEZ: begin
                taken_s   = bus.inst[4];
                pred_pc_s = bus.inst_pc + off21_s;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                taken_s   = bus.inst[25];
                pred_pc_s = bus.inst_pc + off16_s;
            end
            OP_JIRL: begin
`ifdef BRANCH_PREDECODER_RAS_EN
                if (is_ret_s && (ras_cnt_r != CNT_ZERO)) begin
                    taken_s   = 1'b1;
                    pred_pc_s = ras_top_s;
                end else begin
                    taken_s   = 1'b0;
                    pred_pc_s = 32'h0000_0000;
                end
`else
                taken_s   = 1'b0;
                pred_pc_s = 32'h0000_0000;
`endif
            end
            default: begin
                taken_s   = 1'b0;
                pred_pc_s = 32'h0000_0000;
            end
        endcase
    end

    assign redirect_s = accept_s && taken_s;

    // Redirect state machine; target_pc is captured on the cycle the branch is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            target_pc_r <= 32'h0000_0000;
        end else if (bus.flush_all) begin
            state_r     <= IDLE;
            target_pc_r <= target_pc_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect_s) begin
                        state_r     <= REDIRECT;
                        target_pc_r <= pred_pc_s;
                    end else begin
                        state_r     <= IDLE;
                        target_pc_r <= target_pc_r;
                    end
                end
                REDIRECT: begin
                    state_r     <= IDLE;
                    target_pc_r <= target_pc_r;
                end
                default: begin
                    state_r     <= IDLE;
                    target_pc_r <= target_pc_r;
                end
            endcase
        end
    end

`ifdef BRANCH_PREDECODER_RAS_EN
    // Circular stack pointer with a saturating occupancy count; a full push drops the oldest entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_ptr_r <= '0;
            ras_cnt_r <= CNT_ZERO;
        end else if (bus.flush_all) begin
            ras_ptr_r <= ras_ptr_r;
            ras_cnt_r <= CNT_ZERO;
        end else if (push_s) begin
            ras_ptr_r <= ras_ptr_r + PTR_ONE;
            ras_cnt_r <= (ras_cnt_r == CNT_FULL) ? CNT_FULL : (ras_cnt_r + CNT_ONE);
        end else if (pop_s) begin
            ras_ptr_r <= ras_ptr_r - PTR_ONE;
            ras_cnt_r <= ras_cnt_r - CNT_ONE;
        end else begin
            ras_ptr_r <= ras_ptr_r;
            ras_cnt_r <= ras_cnt_r;
        end
    end

    // Return-address storage, written with the link address of the pushing instruction.
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            ras_mem_r[ras_ptr_r] <= bus.inst_pc + 32'd4;
        end
    end
`endif

    assign bus.flush        = redirect_s;
    assign bus.target_valid = (state_r == REDIRECT) && !bus.flush_all;
    assign bus.target_pc    = target_pc_r;

endmodule

// File: tb/tb_branch_predecoder.sv
// Scoreboard bench for branch_predecoder: stimulus queues expected flush/target events,
// a forked monitor pops and compares them on every negative clock edge.
module tb_branch_predecoder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] cyc = 32'd0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        kind;
        logic [31:0] cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    branch_predecoder_if bus ();

    branch_predecoder #(.RAS_DEPTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [31:0] enc_b26(input logic [5:0] op, input logic [25:0] offs);
        return {op, offs[15:0], offs[25:16]};
    endfunction

    function automatic logic [31:0] enc_b16(input logic [5:0] op, input logic [15:0] offs);
        return {op, offs, 5'd4, 5'd5};
    endfunction

    function automatic logic [31:0] enc_b21(input logic [5:0] op, input logic [20:0] offs);
        return {op, offs[15:0], 5'd6, offs[20:16]};
    endfunction

    function automatic logic [31:0] enc_jirl(input logic [4:0] rd, input logic [4:0] rj,
                                              input logic [15:0] offs);
        return {6'b010011, offs, rj, rd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle and queue the events it must produce.
    task automatic issue(input logic [31:0] i, input logic [31:0] pc,
                         input logic exp_flush, input logic exp_tv, input logic [31:0] tgt);
        bus.inst_valid = 1'b1;
        bus.inst       = i;
        bus.inst_pc    = pc;
        if (exp_flush) exp_q.push_back('{kind: 1'b0, cyc: cyc, pc: 32'h0});
        if (exp_tv)    exp_q.push_back('{kind: 1'b1, cyc: cyc + 32'd1, pc: tgt});
        step();
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst       = 32'h0;
        bus.inst_pc    = 32'h0;
        bus.flush_all  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (resetn && (bus.flush || bus.target_valid)) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event: flush=%0b target_valid=%0b pc=%h cycle=%0d, required no event",
                                 bus.flush, bus.target_valid, bus.target_pc, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if ((bus.target_valid !== e.kind) || (cyc !== e.cyc) ||
                            (e.kind && (bus.target_pc !== e.pc))) begin
                            n_err++;
                            $display("FAIL event: got target_valid=%0b cycle=%0d pc=%h, required target_valid=%0b cycle=%0d pc=%h",
                                     bus.target_valid, cyc, bus.target_pc, e.kind, e.cyc, e.pc);
                        end
                    end
                end
            end
        join_none

        #2;
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_target_valid", {31'd0, bus.target_valid}, 32'd0);
        chk("rst_target_pc", bus.target_pc, 32'h0000_0000);
        #10 resetn = 1'b1;
        step();

        // B +0x10 words
        issue(enc_b26(6'b010100, 26'h0000010), 32'h1C00_0000, 1'b1, 1'b1, 32'h1C00_0040);
        step();
        // BNE backward -4 words, then the same forward
        issue(enc_b16(6'b010111, 16'hFFFC), 32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_00F0);
        step();
        issue(enc_b16(6'b010111, 16'h0004), 32'h1C00_0100, 1'b0, 1'b0, 32'h0);
        // BL, then B arriving in the REDIRECT cycle is dropped
        issue(enc_b26(6'b010101, 26'h0000100), 32'h1C00_0200, 1'b1, 1'b1, 32'h1C00_0600);
        issue(enc_b26(6'b010100, 26'h0000004), 32'h1C00_0204, 1'b0, 1'b0, 32'h0);
        step();
        // B accepted, then flush_all cancels the redirect
        issue(enc_b26(6'b010100, 26'h0000008), 32'h1C00_0300, 1'b1, 1'b0, 32'h0);
        bus.flush_all  = 1'b1;
        bus.inst_valid = 1'b1;
        bus.inst       = enc_b26(6'b010100, 26'h0000008);
        #1;
        chk("flush_all_flush", {31'd0, bus.flush}, 32'd0);
        step();
        bus.flush_all  = 1'b0;
        bus.inst_valid = 1'b0;
        issue(enc_b26(6'b010100, 26'h0000002), 32'h1C00_0310, 1'b1, 1'b1, 32'h1C00_0318);
        step();
        // BEQZ backward -8 words, BNEZ forward
        issue(enc_b21(6'b010000, 21'h1FFFF8), 32'h1C00_1000, 1'b1, 1'b1, 32'h1C00_0FE0);
        step();
        issue(enc_b21(6'b010001, 21'h000008), 32'h1C00_1000, 1'b0, 1'b0, 32'h0);
        // BLT with most negative 16-bit offset
        issue(enc_b16(6'b011000, 16'h8000), 32'h1C04_0000, 1'b1, 1'b1, 32'h1C02_0000);
        step();
        // B wrapping below address zero
        issue(enc_b26(6'b010100, 26'h3FFFFF8), 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFF0);
        step();
        // non-branch and BGEU forward
        issue(32'h0280_0000, 32'h1C00_2000, 1'b0, 1'b0, 32'h0);
        issue(enc_b16(6'b011011, 16'h0010), 32'h1C00_2004, 1'b0, 1'b0, 32'h0);
        // JIRL with a non-return form never redirects
        issue(enc_jirl(5'd0, 5'd3, 16'h0000), 32'h1C00_2008, 1'b0, 1'b0, 32'h0);

        // reset pulled low in the middle of the REDIRECT cycle
        issue(enc_b26(6'b010100, 26'h0000004), 32'h1C00_0400, 1'b1, 1'b0, 32'h0);
        chk("tv_before_reset", {31'd0, bus.target_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("tv_at_reset", {31'd0, bus.target_valid}, 32'd0);
        chk("pc_at_reset", bus.target_pc, 32'h0000_0000);
        @(negedge clk);
        #2 resetn = 1'b1;
        step();
        issue(enc_b26(6'b010100, 26'h0000020), 32'h1C00_0500, 1'b1, 1'b1, 32'h1C00_0580);
        step();

`ifdef BRANCH_PREDECODER_RAS_EN
        issue(enc_b26(6'b010101, 26'h0000040), 32'h1C00_0300, 1'b1, 1'b1, 32'h1C00_0400);
        step();
        issue(enc_jirl(5'd0, 5'd1, 16'h0000), 32'h1C00_0800, 1'b1, 1'b1, 32'h1C00_0304);
        step();
        issue(enc_jirl(5'd1, 5'd5, 16'h0000), 32'h1C00_5000, 1'b0, 1'b0, 32'h0);
        issue(enc_jirl(5'd0, 5'd1, 16'h0000), 32'h1C00_0810, 1'b1, 1'b1, 32'h1C00_5004);
        step();
        for (int i = 0; i < 9; i++) begin
            issue(enc_b26(6'b010101, 26'h0000040), 32'h1C00_1000 + 32'(i * 16), 1'b1, 1'b1,
                  32'h1C00_1100 + 32'(i * 16));
            step();
        end
        for (int j = 0; j < 9; j++) begin
            if (j < 8) begin
                issue(enc_jirl(5'd0, 5'd1, 16'h0000), 32'h1C00_3000, 1'b1, 1'b1,
                      32'h1C00_1004 + 32'((8 - j) * 16));
            end else begin
                issue(enc_jirl(5'd0, 5'd1, 16'h0000), 32'h1C00_3000, 1'b0, 1'b0, 32'h0);
            end
            step();
        end
`else
        issue(enc_b26(6'b010101, 26'h0000040), 32'h1C00_0300, 1'b1, 1'b1, 32'h1C00_0400);
        step();
        issue(enc_jirl(5'd0, 5'd1, 16'h0000), 32'h1C00_0800, 1'b0, 1'b0, 32'h0);
        step();
`endif

        repeat (3) step();
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predecoder.md
BRANCH_PREDECODER -- requirements
Module: branch_predecoder

Interface
REQ-001 Parameter RAS_DEPTH, default 8, sets the number of return-address-stack entries; it is a power of two, minimum 2.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port inst_valid, input, 1 bit: a fetched instruction without exception is presented this cycle.
REQ-005 Port inst, input, 32 bits: the fetched instruction word.
REQ-006 Port inst_pc, input, 32 bits: the pc of inst.
REQ-007 Port flush_all, input, 1 bit: pipeline-wide flush (CSR or ROB redirect).
REQ-008 Port flush, output, 1 bit: fetch must stop requesting and drop in-flight responses.
REQ-009 Port target_valid, output, 1 bit: one-cycle pulse; fetch restarts at target_pc.
REQ-010 Port target_pc, output, 32 bits: redirect address, meaningful only while target_valid=1.

Function
REQ-011 Decoding is LoongArch32 opcode inst[31:26]: B 010100, BL 010101, BEQ..BGEU 010110..011011, BEQZ 010000, BNEZ 010001, JIRL 010011.
REQ-012 Offsets: B/BL sext({inst[9:0],inst[25:10]},2'b00); BEQZ/BNEZ sext({inst[4:0],inst[25:10]},2'b00); others sext(inst[25:10],2'b00); all sums are modulo 2^32.
REQ-013 Prediction: B and BL are always taken; a conditional branch is taken iff its offset sign bit is 1 (backward); a forward conditional branch is not taken and causes no redirect.
REQ-014 States: IDLE and REDIRECT.
REQ-015 In IDLE, with inst_valid=1, flush_all=0 and a taken prediction, flush=1 combinationally in the same cycle, target_pc is registered, and the next state is REDIRECT.
REQ-016 In REDIRECT: target_valid=1 and flush=0 for exactly one cycle, inst_valid is ignored, and the next state is IDLE.
REQ-017 Back-to-back redirects are impossible: an instruction arriving in the REDIRECT cycle is dropped without prediction.
REQ-018 While flush_all=1: flush=0, target_valid=0, inst_valid is ignored, and the next state is IDLE; a REDIRECT in progress is cancelled.
REQ-019 Non-branch instructions and not-taken branches leave flush=0 and do not change state.
REQ-020 The block accepts at most one instruction per cycle and never backpressures; it has no ready signal.

Reset
REQ-021 While resetn=0, immediately and independent of clk: state=IDLE, target_pc=0, RAS pointer=0, RAS count=0; outputs flush=0, target_valid=0.
REQ-022 A reset asserted during REDIRECT cancels the pulse; target_valid=0 from the reset instant.

Configuration
REQ-023 Macro BRANCH_PREDECODER_RAS_EN compiles in a RAS of RAS_DEPTH 32-bit entries with a circular pointer and a saturating count.
REQ-024 With the macro defined: an accepted (non-ignored) BL, or a JIRL with rd=1, pushes inst_pc+4.
REQ-025 With the macro defined, JIRL with rd=0, rj=1, offs=0 (return): a non-empty RAS pops and the popped value is predicted via REQ-015; an empty RAS gives no redirect.
REQ-026 With the macro defined: a push when full overwrites the oldest entry and the count stays at RAS_DEPTH; a push plus flush_all in the same cycle does not push; flush_all sets count=0.
REQ-027 With the macro defined, all other JIRL forms give no redirect.
REQ-028 Without the macro: no RAS storage exists, and every JIRL gives no redirect (the backend corrects it).

Verification
REQ-029 B at pc 0x1C000000 with offs26=+0x10 (target 0x1C000040) -> flush=1 that cycle; next cycle target_valid=1, target_pc=0x1C000040; following cycle both 0.
REQ-030 BNE at 0x1C000100 with offs16=-4 -> target_pc 0x1C0000F0 redirect; the same BNE with offs16=+4 -> flush and target_valid stay 0.
REQ-031 BL at 0x1C000200, then a B arriving in the REDIRECT cycle -> the B is ignored and only one target_valid pulse occurs.
REQ-032 B accepted, then flush_all=1 in the next cycle -> target_valid stays 0 and state returns to IDLE.
REQ-033 With RAS_EN: BL at 0x1C000300, then later JIRL r0,r1,0 -> target_pc=0x1C000304; 9 BLs with depth 8, then 9 returns -> 8 redirects, the 9th has none.
REQ-034 resetn pulled low mid-REDIRECT between clock edges -> target_valid drops to 0 immediately; after release, the first taken branch redirects normally.
